// File: rtl/outbox_uart_tx_if.sv
// Outbox FIFO read port as seen by the UART transmitter.
// The transmitter is the master: it issues pops, and the FIFO answers with empty/data.
interface outbox_uart_tx_if;
  logic       i_empty;
  logic [7:0] i_data;
  logic       o_rd;

  modport master (input i_empty, input i_data, output o_rd);
  modport slave  (output i_empty, output i_data, input o_rd);
endinterface

// File: rtl/outbox_uart_tx.sv
// Drains the CPU outbox FIFO and serialises each byte as a UART 8N1 frame on o_tx.
// One pop per frame; the FIFO has a registered read, so data is taken in LOAD, one cycle after POP.
module outbox_uart_tx #(
  parameter int BAUD_DIV = 104,
  parameter int DATA_W   = 8
) (
  input  logic                  clk,
  input  logic                  i_rst,
  outbox_uart_tx_if.master      fifo,
  output logic                  o_tx,
  output logic                  o_busy
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] POP   = 3'd1;
  localparam logic [2:0] LOAD  = 3'd2;
  localparam logic [2:0] START = 3'd3;
  localparam logic [2:0] DATA  = 3'd4;
  localparam logic [2:0] STOP  = 3'd5;

  logic [2:0]        state;
  logic [CW-1:0]     baud;
  logic [2:0]        bitc;
  logic [DATA_W-1:0] shift;
  logic              bit_end;

  assign bit_end = (baud == BAUD_LAST);

  // Strobes decode straight from the state register, so they cannot glitch.
  assign fifo.o_rd = (state == POP);
  assign o_busy    = (state != IDLE);

  // o_tx is updated together with the state transition, so the line level
  // always matches the state that is being entered.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      o_tx  <= 1'b1;
      baud  <= '0;
      bitc  <= '0;
      shift <= '0;
    end else begin
      case (state)
        IDLE: begin
          o_tx <= 1'b1;
          if (!fifo.i_empty) state <= POP;
        end
        POP: state <= LOAD;
        LOAD: begin
          shift <= fifo.i_data;
          baud  <= '0;
          o_tx  <= 1'b0;
          state <= START;
        end
        START: begin
          if (bit_end) begin
            baud  <= '0;
            bitc  <= '0;
            o_tx  <= shift[0];
            state <= DATA;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud  <= '0;
            shift <= shift >> 1;
            if (bitc == 3'd7) begin
              bitc  <= '0;
              o_tx  <= 1'b1;
              state <= STOP;
            end else begin
              bitc <= bitc + 1'b1;
              o_tx <= shift[1];
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            baud  <= '0;
            state <= IDLE;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: begin
          o_tx  <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_outbox_uart_tx.sv
// Bench for outbox_uart_tx at BAUD_DIV=4: a FIFO model feeds bytes, a monitor decodes
// frames off o_tx and compares them against a queue of expected bytes.
module tb_outbox_uart_tx;

  localparam int BD = 4;
  localparam int FRAME = 10 * BD;

  logic clk = 1'b0;
  logic i_rst;
  logic o_tx, o_busy;

  outbox_uart_tx_if fif();

  outbox_uart_tx #(.BAUD_DIV(BD), .DATA_W(8)) dut (
    .clk   (clk),
    .i_rst (i_rst),
    .fifo  (fif),
    .o_tx  (o_tx),
    .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int frames_done = 0;
  int starts[$];
  logic [7:0] exp_q[$];

  // registered-read FIFO model
  logic [7:0] mem [0:31];
  int wp = 0;
  int rp = 0;
  logic [7:0] rdata = 8'h00;
  logic tog_en = 1'b0;
  logic tog = 1'b0;

  assign fif.i_data = rdata;
  always_comb fif.i_empty = tog_en ? tog : (wp == rp);

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (fif.o_rd === 1'b1) begin
      if (rp < wp) rdata <= mem[rp];
      rp <= rp + 1;
    end
  end

  function automatic void chk(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (fif.o_rd === 1'b1) begin
      rd_cnt++;
      if (wp == rp) begin
        errors++;
        $display("FAIL underflow: o_rd=1 with FIFO empty, required no pop");
      end
    end
  end

  // frame monitor: start bit detected at a negedge, then 40 consecutive samples
  initial begin
    logic [FRAME-1:0] smp;
    logic busy_ok, hold_ok, abort;
    logic [7:0] got;
    int st;
    forever begin
      @(negedge clk);
      if (i_rst !== 1'b0 || o_tx !== 1'b0) continue;
      st = cyc;
      smp = '0;
      smp[0] = o_tx;
      busy_ok = (o_busy === 1'b1);
      abort = 1'b0;
      for (int i = 1; i < FRAME; i++) begin
        @(negedge clk);
        if (i_rst !== 1'b0) begin
          abort = 1'b1;
          break;
        end
        smp[i] = o_tx;
        if (o_busy !== 1'b1) busy_ok = 1'b0;
      end
      if (abort) continue;
      hold_ok = 1'b1;
      for (int g = 0; g < 10; g++)
        for (int j = 1; j < BD; j++)
          if (smp[g*BD+j] !== smp[g*BD]) hold_ok = 1'b0;
      for (int b = 0; b < 8; b++) got[b] = smp[(b+1)*BD];
      chk("frame_hold", int'(hold_ok), 1);
      chk("frame_start_stop", int'({smp[0], smp[9*BD]}), 1);
      chk("frame_busy", int'(busy_ok), 1);
      if (exp_q.size() == 0) begin
        chk("unexpected_frame", int'(got), -1);
      end else begin
        chk("frame_data", int'(got), int'(exp_q.pop_front()));
      end
      starts.push_back(st);
      frames_done++;
    end
  end

  task automatic push_byte(input logic [7:0] b);
    mem[wp] = b;
    wp = wp + 1;
  endtask

  task automatic wait_frames(input int target);
    int n = 0;
    while (frames_done < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("frame_timeout", int'(frames_done >= target), 1);
  endtask

  task automatic wait_low();
    int n = 0;
    while (o_tx !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("start_timeout", int'(o_tx === 1'b0), 1);
  endtask

  initial begin
    int base, low, rdh, c0, tgt;
    i_rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_tx", int'(o_tx), 1);
    chk("reset_rd", int'(fif.o_rd), 0);
    chk("reset_busy", int'(o_busy), 0);
    i_rst = 1'b0;

    // long idle with empty FIFO
    base = rd_cnt; low = 0;
    repeat (1000) begin
      @(negedge clk);
      if (o_tx !== 1'b1) low++;
    end
    chk("idle_rd", rd_cnt - base, 0);
    chk("idle_tx_low", low, 0);

    // reset during STOP
    push_byte(8'h5A);
    wait_low();
    repeat (37) @(negedge clk);
    i_rst = 1'b1;
    #1;
    chk("stop_rst_tx", int'(o_tx), 1);
    chk("stop_rst_rd", int'(fif.o_rd), 0);
    chk("stop_rst_busy", int'(o_busy), 0);
    repeat (2) @(negedge clk);
    i_rst = 1'b0;
    base = rd_cnt; low = 0; rdh = 0;
    repeat (100) begin
      @(negedge clk);
      if (o_tx !== 1'b1) low++;
      if (o_busy !== 1'b0) rdh++;
    end
    chk("post_rst_rd", rd_cnt - base, 0);
    chk("post_rst_tx_low", low, 0);
    chk("post_rst_busy", rdh, 0);

    // single byte and start latency
    base = rd_cnt;
    tgt = frames_done + 1;
    exp_q.push_back(8'hA5);
    c0 = cyc;
    push_byte(8'hA5);
    wait_frames(tgt);
    chk("a5_latency", starts[starts.size()-1] - c0, 3);
    chk("a5_rd", rd_cnt - base, 1);

    // back-to-back bytes
    base = rd_cnt;
    tgt = frames_done + 2;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    push_byte(8'h00);
    push_byte(8'hFF);
    wait_frames(tgt);
    chk("b2b_spacing", starts[starts.size()-1] - starts[starts.size()-2], FRAME + 3);
    chk("b2b_rd", rd_cnt - base, 2);

    // i_empty toggling mid-frame
    base = rd_cnt;
    tgt = frames_done + 1;
    exp_q.push_back(8'h3C);
    push_byte(8'h3C);
    wait_low();
    tog_en = 1'b1;
    repeat (30) begin
      @(negedge clk);
      tog = ~tog;
    end
    tog_en = 1'b0;
    wait_frames(tgt);
    repeat (10) @(negedge clk);
    chk("toggle_rd", rd_cnt - base, 1);

    // reset at data bit 4 of 0x81; only 0x42 may appear afterwards
    base = rd_cnt;
    push_byte(8'h81);
    wait_low();
    repeat (4 * (1 + 4) + 1) @(negedge clk);
    i_rst = 1'b1;
    low = 0;
    repeat (3) begin
      @(negedge clk);
      if (o_tx !== 1'b1) low++;
    end
    chk("mid_rst_tx_low", low, 0);
    i_rst = 1'b0;
    repeat (5) @(negedge clk);
    tgt = frames_done + 1;
    exp_q.push_back(8'h42);
    push_byte(8'h42);
    wait_frames(tgt);
    repeat (60) @(negedge clk);
    chk("mid_rst_rd", rd_cnt - base, 2);
    chk("mid_rst_frames", frames_done, tgt);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
